// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: request/response channel between a client and sram_ctrl
interface sram_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-request asynchronous SRAM controller with setup/access/hold/turnaround phases
module sram_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 20,
    parameter int WAIT_CYC = 2,
    parameter int TURN_CYC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_ctrl_if.slave          bus,
    output logic                ce_n,
    output logic                oe_n,
    output logic                we_n,
    output logic [DATA_W/8-1:0] be_n,
    output logic [ADDR_W-1:0]   addr,
    inout  wire  [DATA_W-1:0]   data
);
    localparam int BW      = DATA_W / 8;
    localparam int CNT_MAX = (WAIT_CYC > TURN_CYC) ? WAIT_CYC : TURN_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, TURN} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              armed, we_q, hs, active, last_acc, drive;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, mask;
    logic [BW-1:0]     be_q;

    assign bus.req_ready = armed && state == IDLE;
    assign hs            = bus.req_valid && bus.req_ready;
    assign active        = state inside {SETUP, ACCESS, HOLD};
    assign last_acc      = state == ACCESS && cnt == CW'(WAIT_CYC - 1);
    assign drive         = we_q && (state == ACCESS || state == HOLD);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:    if (hs) state_nx = SETUP;
            SETUP:   begin state_nx = ACCESS; cnt_nx = '0; end
            ACCESS:  if (last_acc) state_nx = HOLD; else cnt_nx = cnt + 1'b1;
            HOLD:    begin state_nx = (we_q || TURN_CYC == 0) ? IDLE : TURN; cnt_nx = '0; end
            TURN:    if (cnt == CW'(TURN_CYC - 1)) state_nx = IDLE; else cnt_nx = cnt + 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < BW; i++) mask[8*i +: 8] = {8{be_q[i]}};
    end

    // armed keeps req_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            armed   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            armed <= 1'b1;
            if (hs) begin
                we_q    <= bus.req_we;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
            end
            if (last_acc && !we_q) rdata_q <= data & mask;
        end
    end

    assign ce_n          = !active;
    assign oe_n          = !(state == ACCESS && !we_q);
    assign we_n          = !(state == ACCESS && we_q);
    assign be_n          = active ? ~be_q : '1;
    assign addr          = addr_q;
    assign data          = drive ? wdata_q : 'z;
    assign bus.rsp_valid = state == HOLD;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: table-driven scoreboard bench for two sram_ctrl configurations with SRAM models
module tb_sram_ctrl;
    typedef struct {
        int          s;
        logic        we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    typedef struct {
        int          s;
        logic [31:0] exp;
        int          hs;
        int          wc;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0, nvec = 0, nerr = 0, viol = 0;
    ent_t q[$];
    ent_t mon_e;
    vec_t tbl [15];
    logic vld [2];
    logic        we_r;
    logic [19:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;

    logic        ce0, oe0, we0, ce1, oe1, we1;
    logic [1:0]  ben0;
    logic [3:0]  ben1;
    logic [19:0] addr0, addr1;
    wire  [15:0] data0;
    wire  [31:0] data1;
    logic [15:0] mem0 [256];
    logic [31:0] mem1 [256];

    logic        ce [2], oe [2], we [2], rdy [2], rv [2];
    logic [3:0]  ben [2];
    logic [19:0] adr [2];
    logic [31:0] dat [2], rd [2], mdat [2];

    sram_ctrl_if #(.DATA_W(16), .ADDR_W(20)) b0 ();
    sram_ctrl_if #(.DATA_W(32), .ADDR_W(20)) b1 ();

    sram_ctrl #(.DATA_W(16), .ADDR_W(20), .WAIT_CYC(2), .TURN_CYC(1)) d0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .ce_n(ce0), .oe_n(oe0), .we_n(we0),
        .be_n(ben0), .addr(addr0), .data(data0)
    );
    sram_ctrl #(.DATA_W(32), .ADDR_W(20), .WAIT_CYC(1), .TURN_CYC(0)) d1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .ce_n(ce1), .oe_n(oe1), .we_n(we1),
        .be_n(ben1), .addr(addr1), .data(data1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign b0.req_valid = vld[0];
    assign b0.req_we    = we_r;
    assign b0.req_addr  = addr_r;
    assign b0.req_wdata = wdata_r[15:0];
    assign b0.req_be    = be_r[1:0];
    assign b1.req_valid = vld[1];
    assign b1.req_we    = we_r;
    assign b1.req_addr  = addr_r;
    assign b1.req_wdata = wdata_r;
    assign b1.req_be    = be_r;

    assign ce[0] = ce0;  assign ce[1] = ce1;
    assign oe[0] = oe0;  assign oe[1] = oe1;
    assign we[0] = we0;  assign we[1] = we1;
    assign ben[0] = {2'b11, ben0};  assign ben[1] = ben1;
    assign adr[0] = addr0;  assign adr[1] = addr1;
    assign dat[0] = {16'h0, data0};  assign dat[1] = data1;
    assign rd[0] = {16'h0, b0.rsp_rdata};  assign rd[1] = b1.rsp_rdata;
    assign rdy[0] = b0.req_ready;  assign rdy[1] = b1.req_ready;
    assign rv[0] = b0.rsp_valid;  assign rv[1] = b1.rsp_valid;
    assign mdat[0] = {16'h0, mem0[addr0[7:0]]};
    assign mdat[1] = mem1[addr1[7:0]];

    // SRAM models drive the whole word on reads so lane masking is left to the controller
    assign data0 = (!ce0 && !oe0) ? mem0[addr0[7:0]] : 16'hzzzz;
    assign data1 = (!ce1 && !oe1) ? mem1[addr1[7:0]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (!ce0 && !we0)
            for (int i = 0; i < 2; i++) if (!ben0[i]) mem0[addr0[7:0]][8*i +: 8] <= data0[8*i +: 8];
        if (!ce1 && !we1)
            for (int j = 0; j < 4; j++) if (!ben1[j]) mem1[addr1[7:0]][8*j +: 8] <= data1[8*j +: 8];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!oe[s] && !we[s]) viol++;
            if (!oe[s] && dat[s] != mdat[s]) viol++;
            if (rv[s]) begin
                if (q.size() == 0 || q[0].s != s) begin
                    nvec++;
                    nerr++;
                    $display("FAIL spurious_rsp%0d: got rsp_valid 1 expected 0", s);
                end else begin
                    mon_e = q.pop_front();
                    chk("rsp_rdata", rd[s], mon_e.exp);
                    chk("rsp_latency", 32'(cyc - mon_e.hs + 1), 32'(mon_e.wc + 2));
                end
            end
        end
    end

    task automatic wait_rdy(input int s);
        int n = 0;
        while (!rdy[s] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[s]) chk("hs_timeout", 32'(rdy[s]), 1);
    endtask

    task automatic do_txn(input vec_t v);
        int          s, hs, wc, tc;
        logic [3:0]  bep;
        logic [31:0] wd;
        s   = v.s;
        wc  = s ? 1 : 2;
        tc  = s ? 0 : 1;
        bep = s ? v.be : {2'b00, v.be[1:0]};
        wd  = s ? v.wdata : {16'h0, v.wdata[15:0]};
        we_r = v.we;
        addr_r = v.addr;
        wdata_r = v.wdata;
        be_r = v.be;
        vld[s] = 1'b1;
        wait_rdy(s);
        hs = cyc + 1;
        q.push_back('{s, v.exp, hs, wc});
        @(negedge clk);
        vld[s] = 1'b0;
        chk("setup_ctl", 32'({ce[s], oe[s], we[s], ben[s]}), 32'({3'b011, ~bep}));
        chk("setup_addr", 32'(adr[s]), 32'(v.addr));
        for (int k = 0; k < wc; k++) begin
            @(negedge clk);
            chk("access_ctl", 32'({ce[s], oe[s], we[s], ben[s]}), 32'({1'b0, v.we, !v.we, ~bep}));
            if (v.we) chk("access_wdata", dat[s], wd);
        end
        @(negedge clk);
        chk("hold_ctl", 32'({ce[s], oe[s], we[s], ben[s]}), 32'({3'b011, ~bep}));
        if (v.we) chk("hold_wdata", dat[s], wd);
        @(negedge clk);
        if (!v.we && tc > 0) begin
            chk("turn_ready", 32'(rdy[s]), 0);
            chk("turn_ctl", 32'({ce[s], oe[s], we[s], ben[s]}), 32'h7F);
            repeat (tc) @(negedge clk);
        end
        chk("next_ready", 32'(rdy[s]), 1);
    endtask

    initial begin
        int n, hs;
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        we_r = 1'b0;
        addr_r = '0;
        wdata_r = '0;
        be_r = '0;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        tbl[0]  = '{0, 1'b1, 20'h00012, 32'h0000_BEEF, 4'h3, 32'h0000_0000};
        tbl[1]  = '{0, 1'b0, 20'h00012, 32'h0,         4'h1, 32'h0000_00EF};
        tbl[2]  = '{0, 1'b0, 20'h00012, 32'h0,         4'h2, 32'h0000_BE00};
        tbl[3]  = '{0, 1'b1, 20'h00034, 32'h0000_1234, 4'h2, 32'h0000_BE00};
        tbl[4]  = '{0, 1'b0, 20'h00034, 32'h0,         4'h3, 32'h0000_1200};
        tbl[5]  = '{0, 1'b1, 20'h00034, 32'h0000_5678, 4'h1, 32'h0000_1200};
        tbl[6]  = '{0, 1'b0, 20'h00034, 32'h0,         4'h3, 32'h0000_1278};
        tbl[7]  = '{0, 1'b1, 20'h00056, 32'h0000_FFFF, 4'h0, 32'h0000_1278};
        tbl[8]  = '{0, 1'b0, 20'h00056, 32'h0,         4'h0, 32'h0000_0000};
        tbl[9]  = '{0, 1'b0, 20'h00012, 32'h0,         4'h3, 32'h0000_BEEF};
        tbl[10] = '{0, 1'b1, 20'hFFFFF, 32'h0000_A5A5, 4'h3, 32'h0000_BEEF};
        tbl[11] = '{0, 1'b0, 20'hFFFFF, 32'h0,         4'h3, 32'h0000_A5A5};
        tbl[12] = '{1, 1'b1, 20'h00005, 32'h1122_3344, 4'h5, 32'h0000_0000};
        tbl[13] = '{1, 1'b0, 20'h00005, 32'h0,         4'hF, 32'h0022_0044};
        tbl[14] = '{1, 1'b0, 20'h00005, 32'h0,         4'h4, 32'h0022_0000};

        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ctl", 32'({ce[s], oe[s], we[s], ben[s]}), 32'h7F);
            chk("rst_addr", 32'(adr[s]), 0);
            chk("rst_ready", 32'(rdy[s]), 0);
            chk("rst_rsp", 32'({rv[s], rd[s][30:0]}), 0);
        end
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 32'(rdy[0]), 0);
        @(negedge clk);
        chk("ready_after_release0", 32'(rdy[0]), 1);
        chk("ready_after_release1", 32'(rdy[1]), 1);

        for (int i = 0; i < 15; i++) do_txn(tbl[i]);

        // read followed by a write with req_valid never dropping
        we_r = 1'b0;
        addr_r = 20'h00012;
        be_r = 4'h3;
        vld[0] = 1'b1;
        wait_rdy(0);
        hs = cyc + 1;
        q.push_back('{0, 32'h0000_BEEF, hs, 2});
        @(negedge clk);
        we_r = 1'b1;
        wdata_r = 32'h0000_C3C3;
        n = 1;
        while (!rdy[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_ready_at", 32'(n), 6);
        hs = cyc + 1;
        q.push_back('{0, 32'h0000_BEEF, hs, 2});
        @(negedge clk);
        vld[0] = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_drain", 32'(q.size()), 0);
        repeat (2) @(negedge clk);
        do_txn('{0, 1'b0, 20'h00012, 32'h0, 4'h3, 32'h0000_C3C3});

        // reset lands in the second access cycle of a write
        we_r = 1'b1;
        addr_r = 20'h00040;
        wdata_r = 32'h0000_7777;
        be_r = 4'h3;
        vld[0] = 1'b1;
        wait_rdy(0);
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_pre_we", 32'(we[0]), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_ctl", 32'({ce[0], oe[0], we[0], ben[0]}), 32'h7F);
        chk("abort_addr", 32'(adr[0]), 0);
        chk("abort_rdata", rd[0], 0);
        chk("abort_ready", 32'(rdy[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_back", 32'(rdy[0]), 1);
        do_txn('{0, 1'b1, 20'h00060, 32'h0000_3C5A, 4'h3, 32'h0000_0000});
        do_txn('{0, 1'b0, 20'h00060, 32'h0,         4'h3, 32'h0000_3C5A});

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 0);
        chk("no_bus_conflict", 32'(viol), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, SRAM data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 20, SRAM word-address width.
REQ-003 Parameter WAIT_CYC, default 2, number of access cycles (OE_N or WE_N low); SHALL be at least 1.
REQ-004 Parameter TURN_CYC, default 1, bus-turnaround idle cycles after a read; 0 is legal.
REQ-005 Clk  in  1  single clock, all state updates on the rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  controller can accept a request this cycle.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  word address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 req_be  in  DATA_W/8  byte enables, active-high; bit i covers Data[8i+7:8i].
REQ-013 rsp_valid  out  1  one-cycle completion pulse, both reads and writes.
REQ-014 rsp_rdata  out  DATA_W  read data, valid while rsp_valid is high after a read.
REQ-015 CE, OE, WE  out  1 each  SRAM chip/output/write enables, active-low.
REQ-016 BE_N  out  DATA_W/8  SRAM byte-lane enables, active-low; generalises UB/LB.
REQ-017 ADDR  out  ADDR_W  SRAM address.
REQ-018 Data  inout  DATA_W  SRAM data bus, tri-stated when not driven.

Function
REQ-019 The FSM SHALL have states IDLE, SETUP, ACCESS, HOLD, TURN.
REQ-020 req_ready SHALL be 1 only in IDLE; a handshake occurs on a rising edge with req_valid and req_ready both 1.
REQ-021 On handshake, req_we, req_addr, req_wdata and req_be SHALL be latched, and the state SHALL go to SETUP; inputs are ignored outside a handshake.
REQ-022 SETUP (1 cycle): CE=0, ADDR=latched address, BE_N=~latched be, OE=1, WE=1, Data Z.
REQ-023 ACCESS (WAIT_CYC cycles, counted by an internal counter): CE=0; read: OE=0, WE=1; write: WE=0, OE=1, Data driven with latched wdata.
REQ-024 Read data SHALL be sampled from Data on the rising edge that ends the last ACCESS cycle; byte lanes with be=0 SHALL be stored as 0x00.
REQ-025 HOLD (1 cycle): CE=0, OE=1, WE=1, ADDR and BE_N unchanged; on a write, Data stays driven; on a read, Data is Z; rsp_valid=1.
REQ-026 After HOLD: write -> IDLE; read with TURN_CYC>0 -> TURN for TURN_CYC cycles -> IDLE; read with TURN_CYC=0 -> IDLE.
REQ-027 In IDLE and TURN: CE=1, OE=1, WE=1, BE_N all 1, Data Z; ADDR holds its last value.
REQ-028 Latency: rsp_valid SHALL be high exactly WAIT_CYC+2 cycles after the handshake edge; the next handshake is possible WAIT_CYC+3 cycles after it for writes, and WAIT_CYC+3+TURN_CYC for reads.
REQ-029 rsp_rdata SHALL hold its value until the next read completes; a write SHALL NOT alter it.
REQ-030 A request with req_be all 0 SHALL still run a full cycle with BE_N all 1 and SHALL produce rsp_valid; on a read, rsp_rdata=0.
REQ-031 Data SHALL never be driven while OE=0, on any cycle.
REQ-032 req_valid held high while req_ready=0 SHALL wait without loss and be accepted on the first IDLE cycle.

Reset
REQ-033 When Reset=0, asynchronously: state IDLE, counter 0, CE/OE/WE=1, BE_N all 1, ADDR=0, Data Z, rsp_valid=0, rsp_rdata=0, req_ready=0.
REQ-034 req_ready SHALL rise on the first rising edge after Reset returns to 1.
REQ-035 Reset during any state SHALL abort the cycle with no rsp_valid; WE SHALL rise in the same cycle reset is asserted.

Verification
REQ-036 Defaults, write 0xBEEF to 0x00012, be=11 -> SETUP, then WE=0 with Data=0xBEEF for 2 cycles, HOLD, rsp_valid 4 cycles after the handshake, req_ready again at +5.
REQ-037 Read 0x00012 from a model holding 0xBEEF, be=01 -> OE=0 for 2 cycles, rsp_rdata=0x00EF with rsp_valid at +4, 1 TURN cycle, req_ready at +6.
REQ-038 Back-to-back: read then write with req_valid held high -> write accepted only after TURN; Data never driven while OE=0.
REQ-039 Reset pulsed in the second ACCESS cycle of a write -> WE=1 and Data Z immediately, no rsp_valid, clean read of a new address afterwards.
REQ-040 DATA_W=32, WAIT_CYC=1, TURN_CYC=0, write be=0101 with data 0x11223344 -> BE_N=1010, rsp_valid at +3; readback gives 0x00220044.
